rifl_rx_frame_commit: RTL and testbench
=======================================

// Module: rifl_rx_frame_commit
// PURPOSE
//  RX stage directly after CRC/frame-ID validation and descrambling. Collects the DWIDTH-bit beats of each
//  FRAME_WIDTH-bit frame, strips the 2-bit header and CRC field, and pushes the payload of CRC-good data frames
//  into a DEPTH-frame FIFO with a valid/ready output. Bad, control and overflowing frames are discarded and counted.
// PARAMETERS
//  FRAME_WIDTH  256  frame size in bits; must be a power-of-two multiple of DWIDTH
//  DWIDTH       64   beat width in bits
//  CRC_WIDTH    12   CRC field width at the bottom of the last beat
//  DEPTH        4    payload FIFO depth in frames; power of two, >= 2
//  CNT_W        16   width of the saturating drop counter
// PORTS
//  clk            in   1                clock
//  rst_n          in   1                synchronous reset, active low
//  rx_up          in   1                link up; low aborts any frame in assembly
//  in_valid       in   1                descrambled beat valid
//  in_sof         in   1                first beat of a frame (qualified by in_valid)
//  in_data        in   DWIDTH           descrambled beat, MSB first in the frame
//  crc_good       in   1                validator verdict; sampled only with the last beat
//  isdata         in   1                header==2'b01; sampled only with the last beat
//  m_valid        out  1                payload FIFO not empty
//  m_ready        in   1                consumer accepts m_data
//  m_data         out  FRAME_WIDTH-2-CRC_WIDTH  frame bits [FRAME_WIDTH-3:CRC_WIDTH]
//  fifo_level     out  $clog2(DEPTH)+1  frames held, for flow-control feedback
//  overflow       out  1                sticky; set when a good data frame finds the FIFO full
//  drop_cnt       out  CNT_W            saturating count of discarded frames (bad CRC, overflow, abort)
// BEHAVIOUR
//  - Reset (rst_n==0 at clk edge): FIFO empty, m_valid=0, fifo_level=0, overflow=0, drop_cnt=0, assembler idle.
//  - N = FRAME_WIDTH/DWIDTH beats. Assembler states IDLE, COLLECT. Beat index counter cnt, width max(1,log2 N).
//  - IDLE: in_valid&in_sof&rx_up -> store beat 0; if N==1 the beat is also the last beat, else -> COLLECT, cnt=1.
//  - IDLE: beats without in_sof are ignored (not counted).
//  - COLLECT: each in_valid beat stored at index cnt, cnt++; beat with cnt==N-1 is the last beat -> IDLE.
//  - COLLECT: in_valid&in_sof restarts the frame at beat 0 (old frame dropped, drop_cnt+1).
//  - rx_up==0 in COLLECT: abort -> IDLE, drop_cnt+1. rx_up==0 in IDLE: no effect.
//  - On the last beat: crc_good&isdata -> commit; crc_good&~isdata -> silent discard (control frame, not
//    counted); ~crc_good -> discard, drop_cnt+1.
//  - Commit writes payload on that clk edge; m_valid and fifo_level reflect it the next cycle (1-cycle latency
//    from last beat to m_valid when the FIFO was empty).
//  - Write accepted if fifo_level<DEPTH, or fifo_level==DEPTH with m_valid&m_ready in the same cycle.
//    Otherwise frame dropped, overflow<=1, drop_cnt+1.
//  - Pop when m_valid&m_ready. m_data is first-word fall-through from the head entry, stable while m_valid&~m_ready.
//  - Simultaneous push+pop leaves fifo_level unchanged. Pointers are log2(DEPTH) bits, wrap modulo DEPTH.
//  - drop_cnt saturates at all-ones, never wraps. overflow clears only on reset.
//  - Two drop causes in one cycle (restart on sof) add 1, not 2.
//  - Reset mid-frame or with a full FIFO discards all contents, no drop count.
// TESTING
//  - N=4, four good data frames payloads A..D, m_ready=1 -> m_valid 1 cycle after each last beat, m_data=A..D in order.
//  - Frame with crc_good=0 on last beat -> no m_valid, drop_cnt 0->1; control frame (isdata=0) -> drop_cnt unchanged.
//  - m_ready=0, 5 good frames, DEPTH=4 -> fifo_level=4, 5th dropped, overflow=1, drop_cnt=1; then drain yields 4 in order.
//  - FIFO full with m_ready=1 on same cycle as 5th last beat -> 5th frame accepted, fifo_level stays 4.
//  - rx_up low after beat 2 -> frame aborted, drop_cnt+1; new sof frame then commits normally.
//  - FRAME_WIDTH==DWIDTH: single-beat frames each commit on their sof beat; drop_cnt held at 2^CNT_W-1 after saturation.

Source files
------------

// File: rtl/rifl_rx_frame_commit.sv
// rifl_rx_frame_commit: assembles RX frames, strips header/CRC and queues good data payloads in a FIFO
module rifl_rx_frame_commit #(
  parameter int FRAME_WIDTH = 256,
  parameter int DWIDTH      = 64,
  parameter int CRC_WIDTH   = 12,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rx_up,
  input  logic                              in_valid,
  input  logic                              in_sof,
  input  logic [DWIDTH-1:0]                 in_data,
  input  logic                              crc_good,
  input  logic                              isdata,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [FRAME_WIDTH-3-CRC_WIDTH:0]  m_data,
  output logic [$clog2(DEPTH):0]            fifo_level,
  output logic                              overflow,
  output logic [CNT_W-1:0]                  drop_cnt
);
  localparam int N  = FRAME_WIDTH / DWIDTH;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = FRAME_WIDTH - 2 - CRC_WIDTH;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [FRAME_WIDTH-1:0] fbuf, frame;
  logic start, restart, abort, last, commit, pop, push, drop;
  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  // frame-level decisions; the last beat is always the bottom slice, so the full frame is fbuf with in_data overlaid there
  always_comb begin
    start   = state == IDLE && in_valid && in_sof && rx_up;
    abort   = state == COLLECT && !rx_up;
    restart = state == COLLECT && rx_up && in_valid && in_sof;
    last    = N == 1 ? start : state == COLLECT && rx_up && in_valid && !in_sof && cnt == LAST;
    frame   = fbuf;
    frame[DWIDTH-1:0] = in_data;
    commit  = last && crc_good && isdata;
    pop     = m_valid && m_ready;
    push    = commit && (fifo_level != FULL_LVL || pop);
    drop    = abort || restart || (last && !crc_good) || (commit && !push);
  end
  // beat assembler: sof (re)starts at beat 0, link drop aborts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else if (start || restart) begin
      fbuf[FRAME_WIDTH-1 -: DWIDTH] <= in_data;
      cnt   <= CW'(1);
      state <= N == 1 ? IDLE : COLLECT;
    end else if (state == COLLECT && in_valid) begin
      fbuf[FRAME_WIDTH-1-int'(cnt)*DWIDTH -: DWIDTH] <= in_data;
      cnt   <= cnt + 1'b1;
      state <= cnt == LAST ? IDLE : COLLECT;
    end
  end
  // payload storage
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= frame[FRAME_WIDTH-3:CRC_WIDTH];
  end
  // FIFO pointers, occupancy, sticky overflow and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push != pop) fifo_level <= push ? fifo_level + 1'b1 : fifo_level - 1'b1;
      if (commit && !push) overflow <= 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
  assign m_valid = fifo_level != '0;
  assign m_data  = mem[rp];
endmodule

// File: tb/tb_rifl_rx_frame_commit.sv
// tb_rifl_rx_frame_commit: directed self-checking bench for the RX frame commit stage
module tb_rifl_rx_frame_commit;
  logic clk = 1'b0, rst_n, rx_up, in_valid, in_sof, crc_good, isdata, m_ready;
  logic [63:0] in_data;
  logic m_valid, overflow, m_valid2, overflow2;
  logic [241:0] m_data;
  logic [49:0] m_data2;
  logic [2:0] fifo_level, fifo_level2;
  logic [15:0] drop_cnt;
  logic [3:0] drop_cnt2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  rifl_rx_frame_commit dut (
    .clk(clk), .rst_n(rst_n), .rx_up(rx_up), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .crc_good(crc_good), .isdata(isdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt)
  );
  rifl_rx_frame_commit #(.FRAME_WIDTH(64), .DWIDTH(64), .CRC_WIDTH(12), .DEPTH(4), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_up(rx_up), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .crc_good(crc_good), .isdata(isdata), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
    .fifo_level(fifo_level2), .overflow(overflow2), .drop_cnt(drop_cnt2)
  );
  function automatic logic [241:0] pay(input int k);
    logic [31:0] w;
    w = 32'h9E3779B9 ^ k;
    return {k[15:0], 2'b10, {7{w}}};
  endfunction
  function automatic logic [255:0] mk(input logic [241:0] p);
    return {2'b01, p, 12'h5A3};
  endfunction
  task automatic do_reset();
    rst_n = 1'b0; rx_up = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    crc_good = 1'b0; isdata = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic beat(input logic [255:0] f, input int i, input logic cg, input logic isd, input logic rl);
    @(negedge clk);
    in_valid = 1'b1; in_sof = i == 0; in_data = f[255-64*i -: 64];
    crc_good = i == 3 ? cg : 1'b0; isdata = i == 3 ? isd : 1'b0;
    if (i == 3 && rl) m_ready = 1'b1;
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; crc_good = 1'b0; isdata = 1'b0;
  endtask
  task automatic send(input logic [255:0] f, input logic cg, input logic isd, input logic rl);
    for (int i = 0; i < 4; i++) beat(f, i, cg, isd, rl);
    idle();
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
  endtask
  task automatic test_in_order();
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(mk(pay(k)), 1'b1, 1'b1, 1'b0);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL order_valid[%0d] got %b exp 1", k, m_valid); end
      checks++; if (m_data !== pay(k)) begin errors++; $display("FAIL order_data[%0d] got %h exp %h", k, m_data, pay(k)); end
    end
    idle();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", m_valid); end
  endtask
  task automatic test_discard();
    do_reset();
    m_ready = 1'b1;
    send(mk(pay(9)), 1'b0, 1'b1, 1'b0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL badcrc_valid got %b exp 0", m_valid); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL badcrc_drop got %0d exp 1", drop_cnt); end
    send(mk(pay(10)), 1'b1, 1'b0, 1'b0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ctrl_valid got %b exp 0", m_valid); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ctrl_drop got %0d exp 1", drop_cnt); end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) send(mk(pay(20 + k)), 1'b1, 1'b1, 1'b0);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop got %0d exp 1", drop_cnt); end
    checks++; if (m_data !== pay(20)) begin errors++; $display("FAIL ovf_hold got %h exp %h", m_data, pay(20)); end
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== pay(20 + k)) begin errors++; $display("FAIL ovf_drain[%0d] got %b/%h exp 1/%h", k, m_valid, m_data, pay(20 + k)); end
      @(negedge clk);
    end
    checks++; if (m_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_empty got %b/%0d exp 0/0", m_valid, fifo_level); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) send(mk(pay(30 + k)), 1'b1, 1'b1, 1'b0);
    send(mk(pay(34)), 1'b1, 1'b1, 1'b1);
    m_ready = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_level got %0d exp 4", fifo_level); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL b2b_nodrop got %b/%0d exp 0/0", overflow, drop_cnt); end
    m_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== pay(30 + k)) begin errors++; $display("FAIL b2b_drain[%0d] got %b/%h exp 1/%h", k, m_valid, m_data, pay(30 + k)); end
      @(negedge clk);
    end
  endtask
  task automatic test_abort();
    do_reset();
    m_ready = 1'b1;
    beat(mk(pay(40)), 0, 1'b1, 1'b1, 1'b0);
    beat(mk(pay(40)), 1, 1'b1, 1'b1, 1'b0);
    idle();
    rx_up = 1'b0;
    @(negedge clk);
    rx_up = 1'b1;
    checks++; if (drop_cnt !== 16'd1 || m_valid !== 1'b0) begin errors++; $display("FAIL abort_drop got %0d/%b exp 1/0", drop_cnt, m_valid); end
    send(mk(pay(41)), 1'b1, 1'b1, 1'b0);
    checks++; if (m_valid !== 1'b1 || m_data !== pay(41)) begin errors++; $display("FAIL abort_next got %b/%h exp 1/%h", m_valid, m_data, pay(41)); end
    beat(mk(pay(42)), 0, 1'b1, 1'b1, 1'b0);
    beat(mk(pay(42)), 1, 1'b1, 1'b1, 1'b0);
    send(mk(pay(43)), 1'b1, 1'b1, 1'b0);
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL restart_drop got %0d exp 2", drop_cnt); end
    checks++; if (m_valid !== 1'b1 || m_data !== pay(43)) begin errors++; $display("FAIL restart_data got %b/%h exp 1/%h", m_valid, m_data, pay(43)); end
  endtask
  task automatic test_single_beat();
    logic [49:0] p;
    p = 50'h3_0123_4567_89AB;
    do_reset();
    m_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_sof = 1'b1; in_data = {2'b01, p, 12'hABC}; crc_good = 1'b1; isdata = 1'b1;
    idle();
    checks++; if (m_valid2 !== 1'b1 || m_data2 !== p) begin errors++; $display("FAIL single_commit got %b/%h exp 1/%h", m_valid2, m_data2, p); end
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sof = 1'b1; in_data = 64'(k); crc_good = 1'b0; isdata = 1'b1;
    end
    idle();
    checks++; if (drop_cnt2 !== 4'd15) begin errors++; $display("FAIL single_drop15 got %0d exp 15", drop_cnt2); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sof = 1'b1; crc_good = 1'b0; isdata = 1'b1;
    end
    idle();
    checks++; if (drop_cnt2 !== 4'd15) begin errors++; $display("FAIL single_sat got %0d exp 15", drop_cnt2); end
    checks++; if (m_valid2 !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", m_valid2); end
  endtask
  initial begin
    test_reset();
    test_in_order();
    test_discard();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_single_beat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
